calc_window_stats: RTL and testbench

- Downstream consumer of the registered signed result `c` produced by the data_select stage.
- Collects fixed-length windows of results and reports three values per window: saturating sum, minimum and maximum.
- Adds a valid/ready handshake, so results can be buffered toward a slower sink or bus interface.
- One held result slot; upstream is stalled only while that slot is occupied and not being drained.

---
 rtl/calc_window_stats_pkg.sv | 43 ++++
 rtl/calc_window_stats_sat_acc.sv | 45 ++++
 rtl/calc_window_stats.sv | 136 +++++++++++++
 tb/tb_calc_window_stats.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_window_stats_pkg.sv
// Shared types and saturating-add helper for the window statistics block
// and its data_select producer.
package calc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 9;

  // Widest sum the helper can clamp; the accumulator width must stay below this.
  localparam int SAT_MAX_W = 32;

  typedef struct packed {
    logic signed [SAT_MAX_W-1:0] sum;
    logic                        ovf;
  } sat_res_t;

  // Adds two sign-extended w-bit values and clamps to the w-bit signed range.
  // The true sign lives in bit w of the (w+1)-bit intermediate, so a mismatch
  // between bits w and w-1 means the w-bit result wrapped.
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input logic [5:0]                  w);
    logic signed [SAT_MAX_W:0]   full;
    logic signed [SAT_MAX_W-1:0] lim;
    sat_res_t                    res;
    full          = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    lim           = '0;
    lim[w - 6'd1] = 1'b1;
    res.ovf       = full[w] ^ full[w - 6'd1];
    if (!res.ovf) begin
      res.sum = full[SAT_MAX_W-1:0];
    end else if (full[w]) begin
      res.sum = -lim;
    end else begin
      res.sum = lim - 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_window_stats_sat_acc.sv
// Saturating signed accumulator with sticky overflow; exposes the value it
// would hold after adding the current sample so the window total can be captured.
module calc_sat_acc
  import calc_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SUM_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_flush,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [SUM_W-1:0]  o_sum_nxt,
  output logic                     o_ovf_nxt
);

  logic signed [SUM_W-1:0] r_sum;
  logic                    r_ovf;
  sat_res_t                w_res;

  always_comb begin
    w_res     = sat_add(SAT_MAX_W'(r_sum), SAT_MAX_W'(i_data), 6'(SUM_W));
    o_sum_nxt = w_res.sum[SUM_W-1:0];
    o_ovf_nxt = r_ovf | w_res.ovf;
  end

  // A flush returns to zero instead of keeping the total, so the next
  // window starts clean without a separate load path.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear || (i_en && i_flush)) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_sum <= o_sum_nxt;
      r_ovf <= o_ovf_nxt;
    end
  end

endmodule

// File: rtl/calc_window_stats.sv
// Collects WIN_LEN signed samples and presents saturated sum, min and max
// through a single held result slot with valid/ready handshakes on both sides.
module calc_window_stats
  import calc_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int WIN_LEN = 8,
  parameter int SUM_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic signed [DATA_W-1:0] out_min,
  output logic signed [DATA_W-1:0] out_max,
  output logic                     out_ovf
);

  localparam int               CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN_LEN - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_count;
  logic signed [DATA_W-1:0] r_min;
  logic signed [DATA_W-1:0] r_max;
  logic signed [SUM_W-1:0] r_out_sum;
  logic signed [DATA_W-1:0] r_out_min;
  logic signed [DATA_W-1:0] r_out_max;
  logic                    r_out_ovf;

  logic                     w_take;
  logic                     w_xfer;
  logic                     w_last;
  logic                     w_first;
  logic signed [DATA_W-1:0] w_min_nxt;
  logic signed [DATA_W-1:0] w_max_nxt;
  logic signed [SUM_W-1:0]  w_sum_nxt;
  logic                     w_ovf_nxt;

  // clear discards any sample offered alongside it.
  assign w_take    = in_valid && in_ready && !clear;
  assign w_xfer    = out_valid && out_ready;
  assign w_last    = w_take && (r_count == LAST);
  assign w_first   = (r_count == '0);
  assign w_min_nxt = (w_first || (in_data < r_min)) ? in_data : r_min;
  assign w_max_nxt = (w_first || (in_data > r_max)) ? in_data : r_max;

  calc_sat_acc #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_en      (w_take),
    .i_flush   (w_last),
    .i_data    (in_data),
    .o_sum_nxt (w_sum_nxt),
    .o_ovf_nxt (w_ovf_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaulting every output first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_last) w_state_nxt = HOLD;
        HOLD:    if (w_xfer && !w_last) w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  // While holding, a sample may enter only if the held result leaves this cycle.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (r_state == HOLD) begin
      in_ready  = out_ready;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
    end else if (clear || w_last) begin
      r_count <= '0;
      r_min   <= '0;
      r_max   <= '0;
    end else if (w_take) begin
      r_count <= r_count + 1'b1;
      r_min   <= w_min_nxt;
      r_max   <= w_max_nxt;
    end
  end

  // Result registers keep their contents across clear; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_sum <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_last) begin
      r_out_sum <= w_sum_nxt;
      r_out_min <= w_min_nxt;
      r_out_max <= w_max_nxt;
      r_out_ovf <= w_ovf_nxt;
    end
  end

  assign out_sum = r_out_sum;
  assign out_min = r_out_min;
  assign out_max = r_out_max;
  assign out_ovf = r_out_ovf;

endmodule

// File: tb/tb_calc_window_stats.sv
// Directed bench: a default instance and a SUM_W=10 instance share all inputs
// so the narrow one exercises saturation on the same sample streams.
module tb_calc_window_stats;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic signed [8:0] in_data;
  logic              out_ready;

  logic              in_ready,  out_valid,  out_ovf;
  logic signed [15:0] out_sum;
  logic signed [8:0] out_min,   out_max;

  logic              in_ready_n, out_valid_n, out_ovf_n;
  logic signed [9:0] out_sum_n;
  logic signed [8:0] out_min_n,  out_max_n;

  int tests_run    = 0;
  int tests_failed = 0;

  calc_window_stats u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_min(out_min), .out_max(out_max), .out_ovf(out_ovf)
  );

  calc_window_stats #(.DATA_W(9), .WIN_LEN(8), .SUM_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_n),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_sum(out_sum_n), .out_min(out_min_n), .out_max(out_max_n), .out_ovf(out_ovf_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  // One sample per cycle; callers keep out_ready high so in_ready is 1.
  task automatic drive_sample(input int d);
    in_valid = 1'b1;
    in_data  = 9'(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b, expected 0", out_valid); end
    tests_run++; if (out_sum !== 16'sd0) begin tests_failed++; $display("FAIL reset_sum: got %0d, expected 0", out_sum); end
    tests_run++; if (out_min !== 9'sd0 || out_max !== 9'sd0) begin tests_failed++; $display("FAIL reset_minmax: got %0d/%0d, expected 0/0", out_min, out_max); end
    tests_run++; if (out_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b, expected 0", out_ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %0b, expected 0", out_valid); end
      end
      drive_sample(i);
    end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %0b, expected 1", out_valid); end
    tests_run++; if (out_sum !== 16'sd36) begin tests_failed++; $display("FAIL basic_sum: got %0d, expected 36", out_sum); end
    tests_run++; if (out_min !== 9'sd1) begin tests_failed++; $display("FAIL basic_min: got %0d, expected 1", out_min); end
    tests_run++; if (out_max !== 9'sd8) begin tests_failed++; $display("FAIL basic_max: got %0d, expected 8", out_max); end
    tests_run++; if (out_ovf !== 1'b0) begin tests_failed++; $display("FAIL basic_ovf: got %0b, expected 0", out_ovf); end
    idle_cycle();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_transfer: got %0b, expected 0", out_valid); end
  endtask

  task automatic test_mixed();
    int mix [8];
    mix = '{-20, 30, -20, 30, 10, -30, -256, 255};
    for (int i = 0; i < 8; i++) drive_sample(mix[i]);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mixed_valid: got %0b, expected 1", out_valid); end
    tests_run++; if (out_sum !== -16'sd1) begin tests_failed++; $display("FAIL mixed_sum: got %0d, expected -1", out_sum); end
    tests_run++; if (out_min !== -9'sd256) begin tests_failed++; $display("FAIL mixed_min: got %0d, expected -256", out_min); end
    tests_run++; if (out_max !== 9'sd255) begin tests_failed++; $display("FAIL mixed_max: got %0d, expected 255", out_max); end
    tests_run++; if (out_ovf !== 1'b0) begin tests_failed++; $display("FAIL mixed_ovf: got %0b, expected 0", out_ovf); end
    idle_cycle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) drive_sample(255);
    tests_run++; if (out_valid_n !== 1'b1) begin tests_failed++; $display("FAIL sat_pos_valid: got %0b, expected 1", out_valid_n); end
    tests_run++; if (out_sum_n !== 10'sd511) begin tests_failed++; $display("FAIL sat_pos_sum: got %0d, expected 511", out_sum_n); end
    tests_run++; if (out_ovf_n !== 1'b1) begin tests_failed++; $display("FAIL sat_pos_ovf: got %0b, expected 1", out_ovf_n); end
    tests_run++; if (out_sum !== 16'sd2040 || out_ovf !== 1'b0) begin tests_failed++; $display("FAIL wide_pos_sum: got %0d ovf %0b, expected 2040 ovf 0", out_sum, out_ovf); end
    for (int i = 0; i < 8; i++) drive_sample(-256);
    tests_run++; if (out_sum_n !== -10'sd512) begin tests_failed++; $display("FAIL sat_neg_sum: got %0d, expected -512", out_sum_n); end
    tests_run++; if (out_ovf_n !== 1'b1) begin tests_failed++; $display("FAIL sat_neg_ovf: got %0b, expected 1", out_ovf_n); end
    tests_run++; if (out_min_n !== -9'sd256 || out_max_n !== -9'sd256) begin tests_failed++; $display("FAIL sat_neg_minmax: got %0d/%0d, expected -256/-256", out_min_n, out_max_n); end
    tests_run++; if (out_sum !== -16'sd2048) begin tests_failed++; $display("FAIL wide_neg_sum: got %0d, expected -2048", out_sum); end
    for (int i = 1; i <= 8; i++) drive_sample(i);
    tests_run++; if (out_sum_n !== 10'sd36) begin tests_failed++; $display("FAIL sat_clear_sum: got %0d, expected 36", out_sum_n); end
    tests_run++; if (out_ovf_n !== 1'b0) begin tests_failed++; $display("FAIL sat_sticky_clears: got %0b, expected 0", out_ovf_n); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 8; i++) drive_sample(i * 10);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = ((c % 2) == 0);
      in_data  = 9'sd100;
      #1;
      tests_run++; if (in_ready !== 1'b0 || in_ready_n !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %0b/%0b, expected 0/0", in_ready, in_ready_n); end
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %0b, expected 1", out_valid); end
      tests_run++; if (out_sum !== 16'sd360 || out_min !== 9'sd10 || out_max !== 9'sd80) begin tests_failed++; $display("FAIL bp_stable: got %0d/%0d/%0d, expected 360/10/80", out_sum, out_min, out_max); end
    end
    in_valid  = 1'b1;
    in_data   = -9'sd5;
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0b, expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_transfer: got %0b, expected 0", out_valid); end
    for (int i = -4; i <= 2; i++) drive_sample(i);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_next_valid: got %0b, expected 1", out_valid); end
    tests_run++; if (out_sum !== -16'sd12 || out_min !== -9'sd5 || out_max !== 9'sd2) begin tests_failed++; $display("FAIL bp_next_result: got %0d/%0d/%0d, expected -12/-5/2", out_sum, out_min, out_max); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int   pulses;
    logic exp_v;
    pulses   = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      in_data = 9'(k);
      @(posedge clk); #1;
      exp_v = ((k % 8) == 7);
      tests_run++; if (out_valid !== exp_v) begin tests_failed++; $display("FAIL b2b_valid_%0d: got %0b, expected %0b", k, out_valid, exp_v); end
      if (out_valid === 1'b1) begin
        pulses++;
        tests_run++; if (out_sum !== 16'(64 * (k / 8) + 28)) begin tests_failed++; $display("FAIL b2b_sum_%0d: got %0d, expected %0d", k, out_sum, 64 * (k / 8) + 28); end
      end
    end
    in_valid = 1'b0;
    tests_run++; if (pulses != 3) begin tests_failed++; $display("FAIL b2b_pulses: got %0d, expected 3", pulses); end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_sample(50);
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || out_ovf !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_flags: got %0b/%0b, expected 0/0", out_valid, out_ovf); end
    tests_run++; if (out_sum !== 16'sd0 || out_min !== 9'sd0 || out_max !== 9'sd0) begin tests_failed++; $display("FAIL rst_mid_values: got %0d/%0d/%0d, expected 0/0/0", out_sum, out_min, out_max); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      if (i == 7) begin
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_early: got %0b, expected 0", out_valid); end
      end
      drive_sample(i);
    end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_valid: got %0b, expected 1", out_valid); end
    tests_run++; if (out_sum !== 16'sd44 || out_min !== 9'sd2 || out_max !== 9'sd9) begin tests_failed++; $display("FAIL rst_mid_result: got %0d/%0d/%0d, expected 44/2/9", out_sum, out_min, out_max); end
    idle_cycle();
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 8; i++) drive_sample(i);
    out_ready = 1'b0;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL clr_hold: got %0b, expected 1", out_valid); end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 9'sd99;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_drop: got %0b, expected 0", out_valid); end
    out_ready = 1'b1;
    idle_cycle();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_discard: got %0b, expected 0", out_valid); end
    for (int i = -7; i <= 0; i++) begin
      if (i == 0) begin
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_early: got %0b, expected 0", out_valid); end
      end
      drive_sample(i);
    end
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL clr_next_valid: got %0b, expected 1", out_valid); end
    tests_run++; if (out_sum !== -16'sd28 || out_min !== -9'sd7 || out_max !== 9'sd0) begin tests_failed++; $display("FAIL clr_next_result: got %0d/%0d/%0d, expected -28/-7/0", out_sum, out_min, out_max); end
    idle_cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_mixed();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
